// File: rtl/bus_source_encoder.sv
// rtl/bus_source_encoder.sv - one-hot bus request to registered 5-bit mux select with hold timeout
// Optional feature: ROUND_ROBIN_EN selects circular arbitration instead of fixed lowest-index priority.
module bus_source_encoder #(
  parameter int NUM_SRC   = 24,
  parameter int SEL_W     = 5,
  parameter int IDLE_CODE = 24,
  parameter int MAX_HOLD  = 16
) (
  input  logic               clock,
  input  logic               clear_n,
  input  logic [NUM_SRC-1:0] req,
  input  logic               err_clr,
  output logic [SEL_W-1:0]   select,
  output logic [NUM_SRC-1:0] grant,
  output logic               bus_valid,
  output logic               conflict,
  output logic               timeout
);

  typedef enum logic {S_IDLE, S_OWN} state_t;

  localparam logic [NUM_SRC-1:0] ONE      = NUM_SRC'(1);
  localparam logic [SEL_W-1:0]   IDLE_SEL = SEL_W'(IDLE_CODE);
  localparam logic [7:0]         HOLD_MAX = 8'(MAX_HOLD);

  state_t             r_state, w_state_nxt;
  logic [SEL_W-1:0]   r_select, w_select_nxt;
  logic [NUM_SRC-1:0] r_grant, w_grant_nxt;
  logic               r_valid, w_valid_nxt;
  logic [7:0]         r_cnt, w_cnt_nxt;
  logic [NUM_SRC-1:0] r_mask, w_mask_nxt;
  logic               r_conflict, r_timeout;

  logic [NUM_SRC-1:0] w_elig;
  logic               w_multi;
  logic               w_found;
  logic [SEL_W-1:0]   w_win;
  logic [SEL_W-1:0]   w_idx;
  logic               w_to;

  assign w_elig  = req & ~r_mask;
  assign w_multi = |(req & (req - ONE));

`ifdef ROUND_ROBIN_EN
  logic [SEL_W-1:0] r_last;

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_idx = SEL_W'((int'(r_last) + 1 + k) % NUM_SRC);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n)
      r_last <= SEL_W'(NUM_SRC - 1);
    else if (r_state == S_IDLE && w_found)
      r_last <= w_win;
  end
`else
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_idx = SEL_W'(k);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_select_nxt = r_select;
    w_grant_nxt  = r_grant;
    w_valid_nxt  = r_valid;
    w_cnt_nxt    = r_cnt;
    w_to         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt  = S_OWN;
          w_select_nxt = w_win;
          w_grant_nxt  = ONE << w_win;
          w_valid_nxt  = 1'b1;
          w_cnt_nxt    = 8'd1;
        end
      end
      S_OWN: begin
        // Any release returns to IDLE, which forces a one-cycle gap before the next owner.
        if (!req[r_select] || r_cnt == HOLD_MAX) begin
          w_to         = req[r_select];
          w_state_nxt  = S_IDLE;
          w_select_nxt = IDLE_SEL;
          w_grant_nxt  = '0;
          w_valid_nxt  = 1'b0;
          w_cnt_nxt    = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_mask_nxt = (r_mask & req) | (w_to ? (ONE << r_select) : '0);
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state    <= S_IDLE;
      r_select   <= IDLE_SEL;
      r_grant    <= '0;
      r_valid    <= 1'b0;
      r_cnt      <= 8'd0;
      r_mask     <= '0;
      r_conflict <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_select   <= w_select_nxt;
      r_grant    <= w_grant_nxt;
      r_valid    <= w_valid_nxt;
      r_cnt      <= w_cnt_nxt;
      r_mask     <= w_mask_nxt;
      r_conflict <= w_multi | (r_conflict & ~err_clr);
      r_timeout  <= w_to | (r_timeout & ~err_clr);
    end
  end

  assign select    = r_select;
  assign grant     = r_grant;
  assign bus_valid = r_valid;
  assign conflict  = r_conflict;
  assign timeout   = r_timeout;

endmodule

// File: doc/bus_source_encoder.md
Name: bus_source_encoder

Overview:
- Control-side producer of the 5-bit bus select code consumed by the datapath's 32-to-1 bus multiplexer.
- Turns one-hot "drive bus" requests from the control unit (register outs, PCout, MDRout, …) into a registered select code plus a one-hot grant.
- Holds bus ownership while the request persists, flags illegal multi-driver requests, and enforces a hold timeout.
- Sits between the control unit and the bus mux select input.

Parameters:
NUM_SRC, 24, number of bus sources; request bit i maps to select code i
SEL_W, 5, width of select code
IDLE_CODE, 24, code driven when no source owns the bus; must decode to the mux's constant-zero path
MAX_HOLD, 16, max consecutive cycles one source may own the bus; range 2..255

Ports:
clock  input  1  system clock, rising edge
clear_n  input  1  asynchronous active-low reset
req  input  NUM_SRC  one-hot drive requests; bit i = source i wants the bus
err_clr  input  1  synchronous clear of the sticky error flags
select  output  SEL_W  registered bus mux select code
grant  output  NUM_SRC  registered one-hot owner; all-zero when idle
bus_valid  output  1  high while a source owns the bus
conflict  output  1  sticky: more than one req bit was seen in one cycle
timeout  output  1  sticky: an owner was force-released at MAX_HOLD

Behaviour:
- Reset (clear_n low, asynchronous; immediate, including mid-grant):
  - select=IDLE_CODE, grant=0, bus_valid=0, conflict=0, timeout=0.
  - State IDLE, hold counter 0, mask 0.
- Two states, IDLE and OWN.
- IDLE:
  - Eligible set = req & ~mask.
  - If the eligible set is non-empty, pick a winner (lowest index, unless the optional feature is enabled).
  - Next edge: select=winner index, grant=1<<winner, bus_valid=1, counter=1, go OWN.
  - Latency: 1 cycle from req to select.
- OWN:
  - If req[owner]=0 at an edge: go IDLE; select=IDLE_CODE, grant=0, bus_valid=0.
  - Mandatory one-cycle idle gap before any new grant; no owner-to-owner switch in one edge.
  - Else if counter==MAX_HOLD: force release as above, set timeout, and set mask[owner].
  - Else: counter+1; outputs unchanged.
  - Requests from other sources are ignored while in OWN; they are not queued.
- Mask:
  - mask[i] clears on any edge where req[i]=0.
  - Prevents an immediate re-grant of a timed-out source.
- Conflict:
  - Set on any edge (any state) where popcount(req)>1.
  - Arbitration still picks a single winner.
- err_clr:
  - Clears conflict and timeout on the next edge.
  - If a set condition occurs on that same edge, the set wins.
- The select code is always in 0..NUM_SRC-1 or IDLE_CODE; no other value is ever driven.
- Counter width is 8 bits; it never wraps because release occurs at MAX_HOLD.
- Outputs come directly from registers; no combinational path from req to select.

Optional Feature:
ROUND_ROBIN_EN
- Defined: winner = first eligible index searched circularly starting at (last_owner+1) mod NUM_SRC.
  - last_owner resets to NUM_SRC-1, so the first search starts at 0.
  - last_owner updates on every grant.
- Undefined: fixed priority, lowest eligible index wins; no last_owner register.
- All other behaviour is identical in both builds.

Test Plan:
- Reset mid-ownership: req=1<<5 for 3 cycles, then pull clear_n low between edges -> select=24, grant=0, bus_valid=0 immediately, without waiting for a clock edge.
- Single request: req=1<<7 for 4 cycles then 0 -> one cycle after req: select=7, grant=0x000080, bus_valid=1 for 4 cycles. One edge after req drops: select=24, bus_valid=0.
- Conflict: req=0x000101 for one cycle -> conflict=1 and select=0 (fixed priority). Pulse err_clr -> conflict=0 next edge.
- Timeout: MAX_HOLD=16, req=1<<3 held 30 cycles -> owner for 16 cycles, then select=24 and timeout=1. No re-grant while req[3] stays high; drop req[3] one cycle and re-raise -> grant again after the idle gap.
- Handover: req=1<<2 then switch to 1<<9 on the same edge -> at least one cycle of select=24 between code 2 and code 9.
- ROUND_ROBIN_EN build: req=0x000011 held, each grant released by pulsing the owner's req low for one cycle -> grants alternate 0,4,0,4. Fixed build under the same stimulus -> always 0.
